// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types and constants for the multi-port register file.
//   rf_state_t  - sequencer state: RF_CLEAR wipes storage after reset, RF_RUN is normal operation
//   RF_ZERO_IDX - index of the hardware-zero register x0
package regfile_pkg;

    typedef enum logic {
        RF_CLEAR = 1'b0,
        RF_RUN   = 1'b1
    } rf_state_t;

    localparam int RF_ZERO_IDX = 0;

endpackage

// File: rtl/regfile_rd_port.sv
// regfile_rd_port: one registered read lane of the register file.
//   clk, rst_n  - clock, synchronous active-low reset (clears data)
//   en          - read enable; data holds when low
//   addr        - register index to read
//   force_zero  - high while storage is being cleared; forces data to 0 regardless of en
//   wr_en       - qualified same-cycle write (already excludes x0 and CLEAR)
//   wr_addr     - same-cycle write index
//   wr_data     - same-cycle write data, forwarded on an address match
//   mem_word    - storage word at addr
//   data        - registered read data, 1-cycle latency
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  force_zero,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [DATA_WIDTH-1:0] mem_word,
    output logic [DATA_WIDTH-1:0] data
);

    logic [DATA_WIDTH-1:0] rd_val;

    // x0 wins over bypass so the physical x0 entry is never observable.
    always_comb begin
        rd_val = mem_word;
        if (addr == ADDR_WIDTH'(RF_ZERO_IDX))
            rd_val = '0;
        else if (wr_en && (wr_addr == addr))
            rd_val = wr_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            data <= '0;
        else if (force_zero)
            data <= '0;
        else if (en)
            data <= rd_val;
    end

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: single-write, NUM_RD-read integer register file with hardware
// zero x0, write-first bypass, per-port read enables, a debug tap and a
// post-reset clear sequencer.
//   clk, rst_n - clock, synchronous active-low reset
//   rd_en      - [NUM_RD] per-port read enables
//   rd_addr    - packed read indices, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   rd_data    - packed registered read data, port i at [i*DATA_WIDTH +: DATA_WIDTH]
//   wr_en, wr_addr, wr_data - write port (x0 writes are discarded)
//   dbg_addr   - debug tap index
//   dbg_data   - registered debug tap data, refreshed every cycle
//   ready      - high once the clear sequence has finished
//   wr_drop    - one-cycle pulse when a write was discarded during CLEAR
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_RD     = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_RD-1:0]            rd_en,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
    output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
    input  logic                         wr_en,
    input  logic [ADDR_WIDTH-1:0]        wr_addr,
    input  logic [DATA_WIDTH-1:0]        wr_data,
    input  logic [ADDR_WIDTH-1:0]        dbg_addr,
    output logic [DATA_WIDTH-1:0]        dbg_data,
    output logic                         ready,
    output logic                         wr_drop
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    if (NUM_RD < 1 || NUM_RD > 4) begin : g_bad_num_rd
        $error("regfile_mp: NUM_RD must be in 1..4");
    end

    rf_state_t             state;
    logic [ADDR_WIDTH-1:0] clr_cnt;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [NUM_RD-1:0][ADDR_WIDTH-1:0] rd_addr_a;
    logic [NUM_RD-1:0][DATA_WIDTH-1:0] rd_data_a;

    logic clearing;
    logic wr_run;

    assign rd_addr_a = rd_addr;
    assign rd_data   = rd_data_a;
    assign clearing  = (state == RF_CLEAR);
    // Only RUN-state writes to a non-zero index reach storage or the bypass.
    assign wr_run    = !clearing && wr_en && (wr_addr != ADDR_WIDTH'(RF_ZERO_IDX));

    // Sequencer. clr_cnt starts at 1 because x0 never needs clearing; it
    // saturates at the top index and stays there through RUN.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= RF_CLEAR;
            clr_cnt <= ADDR_WIDTH'(1);
            ready   <= 1'b0;
            wr_drop <= 1'b0;
        end else if (clearing) begin
            wr_drop <= wr_en;
            if (clr_cnt == {ADDR_WIDTH{1'b1}}) begin
                state <= RF_RUN;
                ready <= 1'b1;
            end else begin
                clr_cnt <= clr_cnt + ADDR_WIDTH'(1);
            end
        end else begin
            wr_drop <= 1'b0;
        end
    end

    // Storage has no reset: it is wiped by the CLEAR walk instead.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (clearing)
                mem[clr_cnt] <= '0;
            else if (wr_run)
                mem[wr_addr] <= wr_data;
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        regfile_rd_port #(
            .DATA_WIDTH (DATA_WIDTH),
            .ADDR_WIDTH (ADDR_WIDTH)
        ) u_port (
            .clk        (clk),
            .rst_n      (rst_n),
            .en         (rd_en[i]),
            .addr       (rd_addr_a[i]),
            .force_zero (clearing),
            .wr_en      (wr_run),
            .wr_addr    (wr_addr),
            .wr_data    (wr_data),
            .mem_word   (mem[rd_addr_a[i]]),
            .data       (rd_data_a[i])
        );
    end

    regfile_rd_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_dbg (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (1'b1),
        .addr       (dbg_addr),
        .force_zero (clearing),
        .wr_en      (wr_run),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .mem_word   (mem[dbg_addr]),
        .data       (dbg_data)
    );

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  rd_en;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;
    logic        ready;
    logic        wr_drop;

    int n_cmp = 0;
    int n_bad = 0;

    regfile_mp #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_RD(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data),
        .ready    (ready),
        .wr_drop  (wr_drop)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_rd(input logic [1:0] en, input logic [4:0] a1, input logic [4:0] a0);
        rd_en   = en;
        rd_addr = {a1, a0};
    endtask

    task automatic set_wr(input logic en, input logic [4:0] a, input logic [31:0] d);
        wr_en   = en;
        wr_addr = a;
        wr_data = d;
    endtask

    initial begin
        rst_n    = 1'b0;
        dbg_addr = 5'd5;
        set_rd(2'b11, 5'd4, 5'd5);
        set_wr(1'b0, 5'd0, 32'h0);

        // Reset then idle clear
        step();
        step();
        chk("rst_ready", {31'b0, ready}, 32'h0);
        chk("rst_lane0", rd_data[31:0], 32'h0);
        chk("rst_lane1", rd_data[63:32], 32'h0);
        chk("rst_dbg", dbg_data, 32'h0);
        chk("rst_wr_drop", {31'b0, wr_drop}, 32'h0);
        rst_n = 1'b1;
        for (int i = 1; i <= 31; i++) begin
            step();
            chk($sformatf("clr1_ready_%0d", i), {31'b0, ready}, (i == 31) ? 32'h1 : 32'h0);
            chk($sformatf("clr1_lane0_%0d", i), rd_data[31:0], 32'h0);
            chk($sformatf("clr1_lane1_%0d", i), rd_data[63:32], 32'h0);
            chk($sformatf("clr1_dbg_%0d", i), dbg_data, 32'h0);
        end

        // Write then read x5 on both ports
        set_rd(2'b00, 5'd0, 5'd0);
        set_wr(1'b1, 5'd5, 32'hDEADBEEF);
        step();
        chk("wr5_lane0_hold", rd_data[31:0], 32'h0);
        chk("wr5_dbg_bypass", dbg_data, 32'hDEADBEEF);
        set_wr(1'b0, 5'd0, 32'h0);
        set_rd(2'b11, 5'd5, 5'd5);
        step();
        chk("rd5_lane0", rd_data[31:0], 32'hDEADBEEF);
        chk("rd5_lane1", rd_data[63:32], 32'hDEADBEEF);
        chk("rd5_dbg", dbg_data, 32'hDEADBEEF);

        // Bypass on port0, x0 on port1
        set_wr(1'b1, 5'd7, 32'h12345678);
        set_rd(2'b11, 5'd0, 5'd7);
        dbg_addr = 5'd7;
        step();
        chk("byp_lane0", rd_data[31:0], 32'h12345678);
        chk("byp_lane1_x0", rd_data[63:32], 32'h0);
        chk("byp_dbg", dbg_data, 32'h12345678);

        // Write to x0 is discarded and silent
        set_wr(1'b1, 5'd0, 32'hFFFFFFFF);
        set_rd(2'b11, 5'd7, 5'd0);
        dbg_addr = 5'd0;
        step();
        chk("x0wr_lane0", rd_data[31:0], 32'h0);
        chk("x0wr_lane1_x7", rd_data[63:32], 32'h12345678);
        chk("x0wr_drop", {31'b0, wr_drop}, 32'h0);
        set_wr(1'b0, 5'd0, 32'h0);
        set_rd(2'b10, 5'd0, 5'd0);
        step();
        chk("x0rd_lane1", rd_data[63:32], 32'h0);
        chk("x0rd_dbg", dbg_data, 32'h0);
        chk("x0rd_drop", {31'b0, wr_drop}, 32'h0);

        // Enable hold on port0
        set_wr(1'b1, 5'd10, 32'hA5A5A5A5);
        step();
        set_wr(1'b0, 5'd0, 32'h0);
        set_rd(2'b01, 5'd0, 5'd10);
        step();
        chk("hold_load", rd_data[31:0], 32'hA5A5A5A5);
        set_wr(1'b1, 5'd3, 32'h1);
        set_rd(2'b00, 5'd0, 5'd3);
        dbg_addr = 5'd3;
        step();
        chk("hold_1", rd_data[31:0], 32'hA5A5A5A5);
        chk("hold_dbg_x3", dbg_data, 32'h1);
        set_wr(1'b0, 5'd0, 32'h0);
        step();
        chk("hold_2", rd_data[31:0], 32'hA5A5A5A5);
        set_rd(2'b01, 5'd0, 5'd3);
        step();
        chk("hold_release", rd_data[31:0], 32'h1);

        // x4 = 7 in RUN, then reset
        set_wr(1'b1, 5'd4, 32'h7);
        step();
        set_wr(1'b0, 5'd0, 32'h0);
        set_rd(2'b10, 5'd4, 5'd0);
        step();
        chk("x4_pre", rd_data[63:32], 32'h7);
        rst_n = 1'b0;
        step();
        chk("rst2_ready", {31'b0, ready}, 32'h0);
        chk("rst2_lane1", rd_data[63:32], 32'h0);
        chk("rst2_dbg", dbg_data, 32'h0);
        rst_n = 1'b1;
        set_rd(2'b11, 5'd4, 5'd5);
        dbg_addr = 5'd4;

        // Partial clear, aborted by reset at clear cycle 20
        for (int i = 1; i <= 19; i++) begin
            step();
            chk($sformatf("clr2_ready_%0d", i), {31'b0, ready}, 32'h0);
            chk($sformatf("clr2_lane1_%0d", i), rd_data[63:32], 32'h0);
            chk($sformatf("clr2_dbg_%0d", i), dbg_data, 32'h0);
        end
        rst_n = 1'b0;
        step();
        chk("rst3_ready", {31'b0, ready}, 32'h0);
        rst_n = 1'b1;

        // Full restarted clear with a write at clear cycle 10
        for (int i = 1; i <= 31; i++) begin
            set_wr(i == 10, 5'd9, 32'h55);
            step();
            chk($sformatf("clr3_ready_%0d", i), {31'b0, ready}, (i == 31) ? 32'h1 : 32'h0);
            chk($sformatf("clr3_drop_%0d", i), {31'b0, wr_drop}, (i == 10) ? 32'h1 : 32'h0);
            chk($sformatf("clr3_lane0_%0d", i), rd_data[31:0], 32'h0);
            chk($sformatf("clr3_dbg_%0d", i), dbg_data, 32'h0);
        end
        set_wr(1'b0, 5'd0, 32'h0);

        // Dropped write and pre-reset contents are gone
        set_rd(2'b11, 5'd4, 5'd9);
        dbg_addr = 5'd5;
        step();
        chk("post_x9", rd_data[31:0], 32'h0);
        chk("post_x4", rd_data[63:32], 32'h0);
        chk("post_x5_dbg", dbg_data, 32'h0);
        chk("post_drop", {31'b0, wr_drop}, 32'h0);
        chk("post_ready", {31'b0, ready}, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-read-port integer register file; next generation of the core's single-write, dual-read register file.
- Adds:
  - configurable read-port count
  - hardware-zero register x0
  - write-to-read bypass
  - per-port read enables
  - generic debug tap (replaces the fixed a0 tap)
  - self-clearing reset sequencer with a ready flag
- Sits in the decode stage; reads are registered (1-cycle latency) to match the pipelined datapath.

Parameters:
- DATA_WIDTH, 32, register width in bits
- ADDR_WIDTH, 5, register index width; depth = 2**ADDR_WIDTH
- NUM_RD, 2, number of read ports (1..4)

Ports:
- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  synchronous, active-low reset
- rd_en  in  NUM_RD  per-port read enable
- rd_addr  in  NUM_RD*ADDR_WIDTH  packed read indices; port i at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- rd_data  out  NUM_RD*DATA_WIDTH  packed registered read data; port i at [i*DATA_WIDTH +: DATA_WIDTH]
- wr_en  in  1  write enable
- wr_addr  in  ADDR_WIDTH  write index
- wr_data  in  DATA_WIDTH  write data
- dbg_addr  in  ADDR_WIDTH  debug tap index
- dbg_data  out  DATA_WIDTH  registered debug tap data, updated every cycle
- ready  out  1  high once clear sequence completes
- wr_drop  out  1  one-cycle pulse: a write was discarded during CLEAR

Behaviour:
- Reset (rst_n low at posedge), any state, including mid-CLEAR:
  - state <= CLEAR, clr_cnt <= 1
  - ready, wr_drop, every rd_data lane and dbg_data <= 0
  - storage contents not touched by reset itself.
- CLEAR:
  - Each posedge with rst_n high writes mem[clr_cnt] <= 0, then clr_cnt++.
  - On the posedge writing index 2**ADDR_WIDTH-1: state <= RUN, ready <= 1.
  - ready rises exactly 2**ADDR_WIDTH-1 posedges after the first posedge with rst_n high (31 at default).
  - wr_en ignored; wr_drop <= wr_en.
  - Reads return 0 and dbg_data = 0 regardless of enables.
- RUN:
  - Write: wr_en && wr_addr != 0 -> mem[wr_addr] <= wr_data at posedge. Writes to x0 are discarded silently (no wr_drop).
  - Read port i, rd_en[i] high: rd_data[i] <= value at posedge. Value is:
    - 0 if rd_addr[i] == 0
    - else wr_data if a same-cycle write targets rd_addr[i] (bypass, write-first)
    - else mem[rd_addr[i]]
  - rd_en[i] low: rd_data[i] holds its previous value.
  - dbg_data: same priority as a read port, updated every cycle, no enable.
  - wr_drop <= 0.
- Multiple ports reading the same index in one cycle all return identical data.
- Read latency: 1 cycle. Write-to-read visibility: 0 cycles via bypass.
- No arithmetic beyond clr_cnt, which is ADDR_WIDTH bits and never wraps (it stops at its maximum).
- x0 is never physically required; a reset-cleared or unwritten x0 entry must be unobservable.
- Out-of-range NUM_RD: elaboration-time error via assertion.

Decomposition:
- Shared package regfile_pkg holds:
  - state enum rf_state_t {RF_CLEAR, RF_RUN}
  - constant RF_ZERO_IDX = 0
- Sub-module regfile_rd_port: one instance per read port via generate, plus one for the debug tap with enable tied high.
  - Inputs: en, addr, force_zero (CLEAR), bypass inputs, mem word.
  - Output: registered data.
- Top module holds the storage array, the CLEAR/RUN FSM and clr_cnt.

Test Plan:
- Reset then idle:
  - rst_n low 2 cycles, then high.
  - ready stays 0 for 30 posedges and is 1 after the 31st.
  - Every rd_data and dbg_data read 0 throughout.
- Write/read:
  - In RUN, write x5 = 0xDEADBEEF.
  - Next cycle rd_en = 2'b11, rd_addr = {5, 5}.
  - Both lanes = 0xDEADBEEF one cycle later.
- Bypass and x0:
  - Same cycle: write x7 = 0x12345678 while port0 reads 7 and port1 reads 0 -> port0 = 0x12345678, port1 = 0.
  - Write x0 = 0xFFFFFFFF, then read x0 -> 0, wr_drop stays 0.
- Enable hold:
  - Port0 holds 0xA5A5A5A5.
  - Deassert rd_en[0], write x3 = 1, set rd_addr[0] = 3 -> rd_data[0] stays 0xA5A5A5A5 until rd_en[0] reasserts.
- Write during CLEAR:
  - Assert wr_en (x9 = 0x55) at clear cycle 10 -> wr_drop pulses 1 cycle.
  - After ready, read x9 -> 0.
- Reset mid-CLEAR and mid-RUN:
  - Pulse rst_n low at clear cycle 20 -> full 31-cycle clear restarts, ready low throughout.
  - In RUN with x4 = 7, pulse reset -> after ready, x4 reads 0.
